mem_nzlat: RTL and testbench
============================

MEM_NZLAT -- requirements
Module: mem_nzlat

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits; a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 1024: number of words.
REQ-003 SHALL have parameter READ_LATENCY, default 5: cycles from read acceptance to ready; at least 1.
REQ-004 SHALL have parameter WRITE_LATENCY, default 5: cycles from write acceptance to ready; at least 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port addr, input, $clog2(DEPTH) bits: word address.
REQ-008 SHALL have port wdata, input, DATA_WIDTH bits: write data.
REQ-009 SHALL have port wstrb, input, DATA_WIDTH/8 bits: byte-lane write enables.
REQ-010 SHALL have port write, input, 1 bit: write request.
REQ-011 SHALL have port read, input, 1 bit: read request.
REQ-012 SHALL have port rdata, output, DATA_WIDTH bits: read data.
REQ-013 SHALL have port ready, output, 1 bit: one-cycle completion pulse for reads and writes.
REQ-014 SHALL store data in an unpacked array named mem_array of DEPTH x DATA_WIDTH, so that hierarchical $readmemh/$writememh from outside the module can reach it.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY and DONE; ready=1 exactly when the state is DONE.
REQ-016 SHALL accept a request only in IDLE, on a rising edge where read or write is 1.
REQ-017 On acceptance SHALL latch addr, wdata, wstrb and the operation type, and ignore those inputs until the next IDLE.
REQ-018 If read and write are both 1 at acceptance, SHALL perform the write; read is ignored.
REQ-019 SHALL assert ready exactly LAT cycles after the acceptance edge (LAT = READ_LATENCY or WRITE_LATENCY), for one cycle; LAT=1 means ready in the cycle immediately after acceptance.
REQ-020 A write SHALL update, at the edge entering DONE, only the bytes of mem_array[addr_latched] whose wstrb bit is 1.
REQ-021 A read SHALL load rdata with mem_array[addr_latched] at the edge entering DONE; rdata SHALL hold that value until the next read completes, and writes SHALL NOT change it.
REQ-022 SHALL ignore requests presented in the DONE cycle; DONE always goes to IDLE, so the earliest next acceptance is the edge after DONE.
REQ-023 The latency counter SHALL be wide enough for max(READ_LATENCY, WRITE_LATENCY) with no wrap-around.
REQ-024 Parameter checks SHALL stop elaboration with a fatal error if READ_LATENCY<1, WRITE_LATENCY<1, or DATA_WIDTH%8!=0.

Reset
REQ-025 While rst=1 at a rising edge: state=IDLE, ready=0, rdata=0, latency counter=0.
REQ-026 Reset SHALL NOT alter mem_array, so preloaded contents survive reset.
REQ-027 Reset during BUSY SHALL abort the operation: no write and no ready pulse.

Configuration
REQ-028 With macro MEM_NZLAT_PROTO_CHECK_EN defined, SHALL include simulation-only checks that issue $error on: read and write both 1 at acceptance; addr/wdata/wstrb/read/write changing while BUSY; rst released with read or write high.
REQ-029 Without MEM_NZLAT_PROTO_CHECK_EN, SHALL contain no checking code; functional behaviour SHALL be identical with and without the macro.

Verification
REQ-030 Preload mem_array[3]=0x12345678, read addr=3 held until ready -> ready high exactly 5 cycles after acceptance for 1 cycle, rdata=0x12345678 and held afterwards.
REQ-031 Write addr=7 wdata=0xDEADBEEF wstrb=0xF, then read addr=7 -> ready after 5 cycles for each operation; read returns 0xDEADBEEF.
REQ-032 Preload mem[2]=0xAABBCCDD, write addr=2 wdata=0x11223344 wstrb=0b0101, then read addr=2 -> 0xAA22CC44.
REQ-033 read=1 held continuously -> accepted only in IDLE: ready pulses are separated by exactly LAT+1 cycles and never high in two consecutive cycles.
REQ-034 Assert rst 2 cycles into a write to addr=9 -> ready stays 0, mem[9] unchanged, rdata=0, next request is accepted normally.
REQ-035 Set READ_LATENCY=1 and WRITE_LATENCY=3 -> read ready 1 cycle after acceptance, write ready 3 cycles after acceptance; read and write both 1 -> write performed.

Source files
------------

// File: rtl/mem_nzlat.sv
// Word-addressed memory with a fixed, non-zero access latency and a one-cycle ready pulse.
// Optional protocol checks are compiled in when MEM_NZLAT_PROTO_CHECK_EN is defined.
module mem_nzlat #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 1024,
  parameter int READ_LATENCY  = 5,
  parameter int WRITE_LATENCY = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [DATA_WIDTH/8-1:0]  wstrb,
  input  logic                     write,
  input  logic                     read,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     ready
);

  localparam int AW      = $clog2(DEPTH);
  localparam int NB      = DATA_WIDTH / 8;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] RL_M1 = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WL_M1 = CW'(WRITE_LATENCY - 1);

  if (READ_LATENCY < 1) begin : g_bad_read_latency
    $fatal(1, "mem_nzlat: READ_LATENCY must be at least 1");
  end
  if (WRITE_LATENCY < 1) begin : g_bad_write_latency
    $fatal(1, "mem_nzlat: WRITE_LATENCY must be at least 1");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $fatal(1, "mem_nzlat: DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  logic [DATA_WIDTH-1:0] mem_array [DEPTH];

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [AW-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         wstrb_q;
  logic                  op_write_q;

  logic                  accept;
  logic                  complete;
  logic [AW-1:0]         c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic [NB-1:0]         c_wstrb;
  logic                  c_write;

  // Handshake: a request is taken on a rising edge in IDLE with read or write high;
  // ready is high for exactly the one DONE cycle; requests in BUSY/DONE are dropped.
  assign accept = (state == IDLE) && (read || write);
  assign ready  = (state == DONE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    complete  = 1'b0;
    c_addr    = addr_q;
    c_wdata   = wdata_q;
    c_wstrb   = wstrb_q;
    c_write   = op_write_q;
    case (state)
      IDLE: begin
        if (accept) begin
          // A latency-1 access completes on the acceptance edge, straight from the inputs.
          c_addr  = addr;
          c_wdata = wdata;
          c_wstrb = wstrb;
          c_write = write;
          if ((write ? WRITE_LATENCY : READ_LATENCY) == 1) begin
            state_nxt = DONE;
            complete  = 1'b1;
            cnt_nxt   = '0;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CW'(1);
          end
        end
      end
      BUSY: begin
        if (cnt == (op_write_q ? WL_M1 : RL_M1)) begin
          state_nxt = DONE;
          complete  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (complete && !c_write) begin
        rdata <= mem_array[c_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q     <= addr;
      wdata_q    <= wdata;
      wstrb_q    <= wstrb;
      op_write_q <= write;
    end
  end

  // Storage is never reset so preloaded contents survive; reset still blocks a pending write.
  always_ff @(posedge clk) begin
    if (!rst && complete && c_write) begin
      for (int b = 0; b < NB; b++) begin
        if (c_wstrb[b]) begin
          mem_array[c_addr][b*8 +: 8] <= c_wdata[b*8 +: 8];
        end
      end
    end
  end

`ifdef MEM_NZLAT_PROTO_CHECK_EN
  logic                  prev_rst;
  logic [AW-1:0]         prev_addr;
  logic [DATA_WIDTH-1:0] prev_wdata;
  logic [NB-1:0]         prev_wstrb;
  logic                  prev_read;
  logic                  prev_write;

  always_ff @(posedge clk) begin
    prev_rst   <= rst;
    prev_addr  <= addr;
    prev_wdata <= wdata;
    prev_wstrb <= wstrb;
    prev_read  <= read;
    prev_write <= write;
    if (!rst && accept && read && write) begin
      $error("mem_nzlat: read and write both high at acceptance");
    end
    if (!rst && (state == BUSY) &&
        ((addr != prev_addr) || (wdata != prev_wdata) || (wstrb != prev_wstrb) ||
         (read != prev_read) || (write != prev_write))) begin
      $error("mem_nzlat: request inputs changed while busy");
    end
    if (prev_rst && !rst && (read || write)) begin
      $error("mem_nzlat: reset released with a request pending");
    end
  end
`endif

endmodule

// File: tb/tb_mem_nzlat.sv
// Scoreboard bench for mem_nzlat: one instance at 5/5 latency, one at read 1 / write 3.
// Drivers push the expected rdata and completion cycle; a monitor checks every ready pulse.
module tb_mem_nzlat;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [2];
  logic [9:0]  addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [3:0]  wstrb_v [2];
  logic        write_v [2];
  logic        read_v  [2];
  logic [31:0] rdata_v [2];
  logic        ready_v [2];

  mem_nzlat #(.DATA_WIDTH(32), .DEPTH(1024), .READ_LATENCY(5), .WRITE_LATENCY(5)) dut0 (
    .clk(clk), .rst(rst_v[0]), .addr(addr_v[0]), .wdata(wdata_v[0]), .wstrb(wstrb_v[0]),
    .write(write_v[0]), .read(read_v[0]), .rdata(rdata_v[0]), .ready(ready_v[0])
  );

  mem_nzlat #(.DATA_WIDTH(32), .DEPTH(1024), .READ_LATENCY(1), .WRITE_LATENCY(3)) dut1 (
    .clk(clk), .rst(rst_v[1]), .addr(addr_v[1]), .wdata(wdata_v[1]), .wstrb(wstrb_v[1]),
    .write(write_v[1]), .read(read_v[1]), .rdata(rdata_v[1]), .ready(ready_v[1])
  );

  typedef struct {
    int          inst;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic prev_ready [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every ready pulse must match the oldest expectation for that instance.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (ready_v[i] === 1'b1) begin
        chk($sformatf("ready_single_cycle%0d", i), {31'd0, prev_ready[i]}, 32'd0);
        if (exp_q.size() == 0 || exp_q[0].inst != i) begin
          checks++;
          errors++;
          $display("FAIL spurious_ready inst %0d at cycle %0d actual 1 expected 0", i, cyc);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("rdata%0d", i), rdata_v[i], e.data);
          chk($sformatf("ready_cycle%0d", i), cyc, e.cyc);
        end
      end
      prev_ready[i] = (ready_v[i] === 1'b1);
    end
  end

  task automatic wait_ready(input int i, input int n, input string name);
    int seen = 0;
    for (int k = 0; k < 100 && seen < n; k++) begin
      @(negedge clk);
      if (ready_v[i] === 1'b1) seen++;
    end
    if (seen < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual %0d pulses expected %0d", name, seen, n);
      exp_q.delete();
    end
  endtask

  // One request: drive for one edge, then scramble the inputs to prove they were latched.
  task automatic op(input int i, input logic wr, input logic rd, input logic [9:0] a,
                    input logic [31:0] d, input logic [3:0] s, input int lat,
                    input logic [31:0] exp_rdata, input string name);
    exp_t e;
    @(posedge clk); #1;
    write_v[i] = wr; read_v[i] = rd; addr_v[i] = a; wdata_v[i] = d; wstrb_v[i] = s;
    @(posedge clk); #1;
    e.inst = i; e.data = exp_rdata; e.cyc = cyc + lat - 1;
    exp_q.push_back(e);
    write_v[i] = 1'b0; read_v[i] = 1'b0; addr_v[i] = ~a; wdata_v[i] = ~d; wstrb_v[i] = ~s;
    wait_ready(i, 1, name);
    @(posedge clk);
  endtask

  initial begin
    exp_t e;
    int   base;
    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b1; addr_v[i] = '0; wdata_v[i] = '0; wstrb_v[i] = '0;
      write_v[i] = 1'b0; read_v[i] = 1'b0; prev_ready[i] = 1'b0;
    end
    dut0.mem_array[3] = 32'h12345678;
    dut0.mem_array[2] = 32'hAABBCCDD;
    dut0.mem_array[9] = 32'h00000055;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready0", {31'd0, ready_v[0]}, 32'd0);
    chk("reset_rdata0", rdata_v[0], 32'd0);
    chk("reset_ready1", {31'd0, ready_v[1]}, 32'd0);
    chk("reset_rdata1", rdata_v[1], 32'd0);
    @(posedge clk); #1;
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;

    op(0, 1'b0, 1'b1, 10'd3, 32'h0, 4'h0, 5, 32'h12345678, "read_preload3");
    op(0, 1'b1, 1'b0, 10'd7, 32'hDEADBEEF, 4'hF, 5, 32'h12345678, "write7");
    op(0, 1'b0, 1'b1, 10'd7, 32'h0, 4'h0, 5, 32'hDEADBEEF, "read7");
    op(0, 1'b1, 1'b0, 10'd2, 32'h11223344, 4'b0101, 5, 32'hDEADBEEF, "write2_strb");
    op(0, 1'b0, 1'b1, 10'd2, 32'h0, 4'h0, 5, 32'hAA22CC44, "read2_merged");
    op(0, 1'b1, 1'b0, 10'd7, 32'h00000000, 4'h0, 5, 32'hAA22CC44, "write7_nostrb");
    op(0, 1'b0, 1'b1, 10'd7, 32'h0, 4'h0, 5, 32'hDEADBEEF, "read7_unchanged");

    // Held read: pulses every LAT+1 = 6 cycles.
    @(posedge clk); #1;
    read_v[0] = 1'b1; addr_v[0] = 10'd3;
    @(posedge clk); #1;
    base = cyc;
    for (int k = 0; k < 3; k++) begin
      e.inst = 0; e.data = 32'h12345678; e.cyc = base + 4 + k * 6;
      exp_q.push_back(e);
    end
    wait_ready(0, 3, "held_read");
    read_v[0] = 1'b0;
    repeat (2) @(posedge clk);

    // Reset two cycles into a write: no ready, no write, rdata cleared.
    #1;
    write_v[0] = 1'b1; addr_v[0] = 10'd9; wdata_v[0] = 32'hFFFFFFFF; wstrb_v[0] = 4'hF;
    @(posedge clk); #1;
    write_v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_v[0] = 1'b1;
    @(posedge clk); #1;
    rst_v[0] = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'd0, ready_v[0]}, 32'd0);
    chk("abort_rdata", rdata_v[0], 32'd0);
    repeat (4) @(posedge clk);
    op(0, 1'b0, 1'b1, 10'd9, 32'h0, 4'h0, 5, 32'h00000055, "read9_after_abort");

    op(1, 1'b1, 1'b0, 10'd4, 32'hCAFEF00D, 4'hF, 3, 32'h00000000, "lat_write4");
    op(1, 1'b0, 1'b1, 10'd4, 32'h0, 4'h0, 1, 32'hCAFEF00D, "lat1_read4");
    op(1, 1'b1, 1'b1, 10'd5, 32'h0BADF00D, 4'hF, 3, 32'hCAFEF00D, "both_is_write5");
    op(1, 1'b0, 1'b1, 10'd5, 32'h0, 4'h0, 1, 32'h0BADF00D, "lat1_read5");
    op(1, 1'b1, 1'b0, 10'd5, 32'h99887766, 4'b0011, 3, 32'h0BADF00D, "write5_low");
    op(1, 1'b0, 1'b1, 10'd5, 32'h0, 4'h0, 1, 32'h0BAD7766, "read5_merged");

    repeat (10) @(posedge clk);
    chk("leftover_expectations", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
